// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if
//   Groups the control/data bus of the universal shift register so that the
//   design and its user exchange one handle instead of ten loose signals.
//   clk and rst_n stay as plain ports on the design.
//
//   Signals:
//     en        enable. When 0, the register and the counter hold.
//     mode[2:0] operation select.
//     si_r      serial input that enters at the MSB on a right shift.
//     si_l      serial input that enters at the LSB on a left shift.
//     pd        parallel load data.
//     q         register contents.
//     so_r      right serial output, equal to q[0].
//     so_l      left serial output, equal to q[NBITS-1].
//     bit_cnt   number of shifts taken in the current word.
//     word_done one-cycle pulse that marks a completed word.
//
//   Modports:
//     master  the user side. It drives en, mode, si_r, si_l and pd.
//     slave   the register side. It drives q, so_r, so_l, bit_cnt and word_done.
interface univ_shift_reg_if #(
  parameter int NBITS = 4
);
  localparam int CNT_W = $clog2(NBITS);

  logic             en;
  logic [2:0]       mode;
  logic             si_r;
  logic             si_l;
  logic [NBITS-1:0] pd;
  logic [NBITS-1:0] q;
  logic             so_r;
  logic             so_l;
  logic [CNT_W-1:0] bit_cnt;
  logic             word_done;

  modport master (
    output en, mode, si_r, si_l, pd,
    input  q, so_r, so_l, bit_cnt, word_done
  );

  modport slave (
    input  en, mode, si_r, si_l, pd,
    output q, so_r, so_l, bit_cnt, word_done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   NBITS-wide universal shift register. The operation is chosen on every
//   cycle and can be one of: hold, shift right, shift left, parallel load,
//   rotate right, rotate left, arithmetic shift right, or clear.
//   A shift counter groups every NBITS shift-class operations into one word.
//   When a word completes, the register pulses word_done for one cycle.
//
//   Ports:
//     clk    clock. All state updates on the rising edge.
//     rst_n  synchronous, active-low reset. It has priority over en and mode.
//     bus    univ_shift_reg_if slave modport (en/mode/si_r/si_l/pd in,
//            q/so_r/so_l/bit_cnt/word_done out).
//
//   Parameters:
//     NBITS      register width, NBITS >= 2. Must match the interface instance.
//     RESET_VAL  value of q after reset.
module univ_shift_reg #(
  parameter int               NBITS     = 4,
  parameter logic [NBITS-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  univ_shift_reg_if.slave   bus
);
  localparam int               CNT_W   = $clog2(NBITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NBITS - 1);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  op_e              op;
  logic [NBITS-1:0] q_reg,    q_next;
  logic [CNT_W-1:0] cnt_reg,  cnt_next;
  logic             done_reg, done_next;
  logic             is_shift;

  assign op = op_e'(bus.mode);

  always_comb begin
    q_next    = q_reg;
    cnt_next  = cnt_reg;
    done_next = 1'b0;
    is_shift  = 1'b0;

    if (bus.en) begin
      case (op)
        OP_SHR: begin
          q_next   = {bus.si_r, q_reg[NBITS-1:1]};
          is_shift = 1'b1;
        end
        OP_SHL: begin
          q_next   = {q_reg[NBITS-2:0], bus.si_l};
          is_shift = 1'b1;
        end
        OP_LOAD: begin
          q_next   = bus.pd;
          cnt_next = '0;
        end
        OP_ROR: begin
          q_next   = {q_reg[0], q_reg[NBITS-1:1]};
          is_shift = 1'b1;
        end
        OP_ROL: begin
          q_next   = {q_reg[NBITS-2:0], q_reg[NBITS-1]};
          is_shift = 1'b1;
        end
        OP_ASR: begin
          q_next   = {q_reg[NBITS-1], q_reg[NBITS-1:1]};
          is_shift = 1'b1;
        end
        OP_CLR: begin
          // Clear goes to zero, not RESET_VAL. Clear is a datapath operation,
          // not a reset.
          q_next   = '0;
          cnt_next = '0;
        end
        default: ;  // OP_HOLD
      endcase
    end

    // Compare against NBITS-1 explicitly. A natural rollover of the counter
    // would only give the right wrap point when NBITS is a power of two.
    if (is_shift) begin
      if (cnt_reg == CNT_MAX) begin
        cnt_next  = '0;
        done_next = 1'b1;
      end else begin
        cnt_next  = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg    <= RESET_VAL;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

  assign bus.q         = q_reg;
  assign bus.so_r      = q_reg[0];
  assign bus.so_l      = q_reg[NBITS-1];
  assign bus.bit_cnt   = cnt_reg;
  assign bus.word_done = done_reg;
endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;
  logic clk = 1'b0;
  logic rst4_n;
  logic rst8_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  univ_shift_reg_if #(.NBITS(4)) bus4 ();
  univ_shift_reg_if #(.NBITS(8)) bus8 ();

  univ_shift_reg #(.NBITS(4), .RESET_VAL(4'h0)) dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .bus   (bus4.slave)
  );

  univ_shift_reg #(.NBITS(8), .RESET_VAL(8'hA5)) dut8 (
    .clk   (clk),
    .rst_n (rst8_n),
    .bus   (bus8.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample one edge later, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] eq, input logic [1:0] ecnt,
                      input logic ewd);
    check({tag, ".q"},         32'(bus4.q),         32'(eq));
    check({tag, ".bit_cnt"},   32'(bus4.bit_cnt),   32'(ecnt));
    check({tag, ".word_done"}, 32'(bus4.word_done), 32'(ewd));
    $display("[TB] %s q=%b bit_cnt=%0d word_done=%0b", tag, bus4.q, bus4.bit_cnt, bus4.word_done);
  endtask

  // One enabled operation on the 4-bit instance.
  task automatic op4(input logic [2:0] m, input logic sr, input logic sl, input logic [3:0] d);
    bus4.en   = 1'b1;
    bus4.mode = m;
    bus4.si_r = sr;
    bus4.si_l = sl;
    bus4.pd   = d;
    step();
  endtask

  initial begin
    logic [7:0] exp8;

    rst4_n    = 1'b0;
    rst8_n    = 1'b0;
    bus8.en   = 1'b0;
    bus8.mode = 3'b000;
    bus8.si_r = 1'b0;
    bus8.si_l = 1'b0;
    bus8.pd   = 8'h00;

    // 1. Reset dominance over a pending load.
    op4(3'b011, 1'b0, 1'b0, 4'b1010);
    chk4("rst_a", 4'b0000, 2'd0, 1'b0);
    op4(3'b011, 1'b0, 1'b0, 4'b1010);
    chk4("rst_b", 4'b0000, 2'd0, 1'b0);
    rst4_n = 1'b1;

    // 2. Shift right a full word.
    op4(3'b001, 1'b1, 1'b0, 4'h0); chk4("shr1", 4'b1000, 2'd1, 1'b0);
    op4(3'b001, 1'b0, 1'b0, 4'h0); chk4("shr2", 4'b0100, 2'd2, 1'b0);
    op4(3'b001, 1'b1, 1'b0, 4'h0); chk4("shr3", 4'b1010, 2'd3, 1'b0);
    op4(3'b001, 1'b1, 1'b0, 4'h0); chk4("shr4", 4'b1101, 2'd0, 1'b1);
    check("shr4.so_r", 32'(bus4.so_r), 32'd1);
    check("shr4.so_l", 32'(bus4.so_l), 32'd1);

    // 3. Load and rotates.
    op4(3'b011, 1'b0, 1'b0, 4'b1001); chk4("load1001", 4'b1001, 2'd0, 1'b0);
    op4(3'b101, 1'b0, 1'b0, 4'h0);    chk4("rol",      4'b0011, 2'd1, 1'b0);
    op4(3'b100, 1'b0, 1'b0, 4'h0);    chk4("ror1",     4'b1001, 2'd2, 1'b0);
    op4(3'b100, 1'b0, 1'b0, 4'h0);    chk4("ror2",     4'b1100, 2'd3, 1'b0);
    check("ror2.so_r", 32'(bus4.so_r), 32'd0);
    check("ror2.so_l", 32'(bus4.so_l), 32'd1);

    // 4. Arithmetic shift right and clear.
    op4(3'b011, 1'b0, 1'b0, 4'b1000); chk4("load1000", 4'b1000, 2'd0, 1'b0);
    op4(3'b110, 1'b0, 1'b0, 4'h0);    chk4("asr1",     4'b1100, 2'd1, 1'b0);
    op4(3'b110, 1'b0, 1'b0, 4'h0);    chk4("asr2",     4'b1110, 2'd2, 1'b0);
    op4(3'b011, 1'b0, 1'b0, 4'b0110); chk4("load0110", 4'b0110, 2'd0, 1'b0);
    op4(3'b110, 1'b0, 1'b0, 4'h0);    chk4("asr3",     4'b0011, 2'd1, 1'b0);
    op4(3'b111, 1'b0, 1'b0, 4'h0);    chk4("clear",    4'b0000, 2'd0, 1'b0);

    // 5. Enable gating and mid-word events.
    op4(3'b010, 1'b0, 1'b1, 4'h0); chk4("shl1", 4'b0001, 2'd1, 1'b0);
    op4(3'b010, 1'b0, 1'b1, 4'h0); chk4("shl2", 4'b0011, 2'd2, 1'b0);
    bus4.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk4("en0", 4'b0011, 2'd2, 1'b0);
    end
    op4(3'b000, 1'b0, 1'b1, 4'hF); chk4("hold", 4'b0011, 2'd2, 1'b0);
    op4(3'b011, 1'b0, 1'b0, 4'b0101); chk4("load0101", 4'b0101, 2'd0, 1'b0);
    op4(3'b010, 1'b0, 1'b0, 4'h0); chk4("w_shl1", 4'b1010, 2'd1, 1'b0);
    op4(3'b010, 1'b0, 1'b0, 4'h0); chk4("w_shl2", 4'b0100, 2'd2, 1'b0);
    op4(3'b010, 1'b0, 1'b0, 4'h0); chk4("w_shl3", 4'b1000, 2'd3, 1'b0);
    op4(3'b010, 1'b0, 1'b0, 4'h0); chk4("w_shl4", 4'b0000, 2'd0, 1'b1);
    op4(3'b000, 1'b0, 1'b0, 4'h0); chk4("w_after", 4'b0000, 2'd0, 1'b0);
    op4(3'b001, 1'b1, 1'b0, 4'h0); chk4("m_shr1", 4'b1000, 2'd1, 1'b0);
    op4(3'b001, 1'b1, 1'b0, 4'h0); chk4("m_shr2", 4'b1100, 2'd2, 1'b0);
    op4(3'b001, 1'b1, 1'b0, 4'h0); chk4("m_shr3", 4'b1110, 2'd3, 1'b0);
    rst4_n = 1'b0;
    op4(3'b001, 1'b1, 1'b0, 4'h0); chk4("m_rst",  4'b0000, 2'd0, 1'b0);
    rst4_n = 1'b1;
    op4(3'b000, 1'b0, 1'b0, 4'h0); chk4("m_post", 4'b0000, 2'd0, 1'b0);

    // 6. 8-bit instance with a non-zero reset value.
    check("w8.rst.q",       32'(bus8.q),       32'h0A5);
    check("w8.rst.bit_cnt", 32'(bus8.bit_cnt), 32'd0);
    $display("[TB] w8.rst q=%h bit_cnt=%0d", bus8.q, bus8.bit_cnt);
    rst8_n    = 1'b1;
    bus8.en   = 1'b1;
    bus8.mode = 3'b010;
    bus8.si_l = 1'b0;
    exp8      = 8'hA5;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp8 = {exp8[6:0], 1'b0};
      check("w8.shl.q",         32'(bus8.q),         32'(exp8));
      check("w8.shl.bit_cnt",   32'(bus8.bit_cnt),   32'(k % 8));
      check("w8.shl.word_done", 32'(bus8.word_done), (k == 8) ? 32'd1 : 32'd0);
      $display("[TB] w8.shl%0d q=%h bit_cnt=%0d word_done=%0b", k, bus8.q, bus8.bit_cnt,
               bus8.word_done);
    end
    bus8.si_l = 1'b1;
    step();
    check("w8.next.q",         32'(bus8.q),         32'h01);
    check("w8.next.bit_cnt",   32'(bus8.bit_cnt),   32'd1);
    check("w8.next.word_done", 32'(bus8.word_done), 32'd0);
    $display("[TB] w8.next q=%h bit_cnt=%0d word_done=%0b", bus8.q, bus8.bit_cnt, bus8.word_done);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register. It generalises the plain 4-bit right-shift stage to NBITS width.
- Operation is selectable per cycle: hold, shift right, shift left, parallel load, rotate right, rotate left, arithmetic shift right, or clear.
- A shift counter frames every NBITS serial shifts as one word and pulses word_done.
- Serves as the common serial/parallel conversion element for the digital-system lab datapaths.

Parameters:
- NBITS, 4: register width; legal range is NBITS >= 2.
- RESET_VAL, 0: value loaded into q on reset, NBITS bits wide.
- CNT_W, $clog2(NBITS) (derived, not overridden): width of bit_cnt.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  operation enable; when 0, q and bit_cnt hold.
- mode  input  3  operation select (encoding in Behaviour).
- si_r  input  1  serial input entering at the MSB on shift right.
- si_l  input  1  serial input entering at the LSB on shift left.
- pd  input  NBITS  parallel load data.
- q  output  NBITS  register contents (registered).
- so_r  output  1  right serial output, equal to q[0].
- so_l  output  1  left serial output, equal to q[NBITS-1].
- bit_cnt  output  CNT_W  number of shifts taken in the current word, 0..NBITS-1.
- word_done  output  1  one-cycle pulse marking a completed word.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
  - Sampled on the rising edge of clk when rst_n=0.
  - Reset has priority over en and mode.
- Reset values: q=RESET_VAL, bit_cnt=0, word_done=0.
- so_r and so_l are combinational taps of q.
- mode encoding, applied on the rising edge when en=1:
  - 000 hold: q unchanged.
  - 001 shift right: q <= {si_r, q[NBITS-1:1]}.
  - 010 shift left: q <= {q[NBITS-2:0], si_l}.
  - 011 load: q <= pd.
  - 100 rotate right: q <= {q[0], q[NBITS-1:1]}.
  - 101 rotate left: q <= {q[NBITS-2:0], q[NBITS-1]}.
  - 110 arithmetic shift right: q <= {q[NBITS-1], q[NBITS-1:1]}.
  - 111 clear: q <= 0 (not RESET_VAL).
- Shift-class modes are 001, 010, 100, 101 and 110.
- Counter, when en=1:
  - A shift-class mode increments bit_cnt. When bit_cnt=NBITS-1 it wraps to 0 instead.
  - Load (011) and clear (111) force bit_cnt to 0.
  - Hold (000) leaves bit_cnt unchanged.
- word_done (registered):
  - Goes to 1 on the edge where bit_cnt wraps NBITS-1 -> 0; otherwise 0.
  - It is therefore high for exactly one cycle, aligned with q holding the completed word.
  - A word may mix shift directions; the counter counts operations, not direction.
- en=0: q and bit_cnt hold; word_done is 0 on the next edge.
- Hold mode with en=1: same as en=0 for q and bit_cnt; word_done is 0.
- Latency: every operation is visible on q one edge after it is sampled. There is no multi-cycle path.
- Reset mid-word: the partial word is discarded (bit_cnt=0) and no word_done is generated.
- Back-to-back words: a shift on the cycle word_done is high counts as shift 1 of the next word, with no gap.
- Undefined or X inputs are not checked; mode is fully decoded, so no illegal states exist.

Test Plan (NBITS=4, RESET_VAL=0 unless stated):
1. Reset dominance: hold rst_n=0 for 2 edges with en=1, mode=011, pd=1010 -> q=0000, bit_cnt=0, word_done=0 throughout.
2. Shift right, a full word from 0000, mode=001, si_r=1,0,1,1 on successive edges:
   - q=1000, 0100, 1010, 1101.
   - bit_cnt=1, 2, 3, 0.
   - word_done=1 only in the cycle after the 4th edge; so_r=1, so_l=1.
3. Load and rotates: load pd=1001 -> q=1001, bit_cnt=0. Then:
   - rotate left -> 0011.
   - rotate right -> 1001, then another rotate right -> 1100.
   - bit_cnt=3; no word_done.
4. Arithmetic shift right and clear:
   - load 1000, then ASR twice -> 1100, then 1110.
   - load 0110, then ASR -> 0011.
   - clear -> 0000, bit_cnt=0.
5. Enable and mid-word events:
   - two shift-left edges with si_l=1 from 0000 -> 0011, bit_cnt=2.
   - en=0 with mode=010 for 3 edges -> q=0011 and bit_cnt=2 unchanged.
   - load 0101 -> bit_cnt=0; then word_done appears only after 4 further shifts.
   - separately, assert rst_n=0 at bit_cnt=3 -> q=0000, bit_cnt=0, word_done stays 0.
6. Generic width, NBITS=8, RESET_VAL=8'hA5:
   - reset -> q=A5.
   - 8 shift-left edges with si_l=0 -> q=00, word_done high for exactly one cycle after the 8th edge.
   - a 9th shift-left edge with si_l=1 in the word_done cycle -> q=01, bit_cnt=1.
